// File: rtl/axi_sram_pkg.sv
// axi_sram_pkg: shared codes, FSM encoding, default widths and R-beat
// record for the AXI3 SRAM read slave.
package axi_sram_pkg;

  localparam int ID_W_DEF    = 4;
  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int SRAM_AW_DEF = 14;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // One R beat as it travels through the skid FIFO.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } rbeat_t;

  // WRAP is only meaningful for power-of-two beat counts.
  function automatic logic wrap_len_ok(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

endpackage

// File: rtl/axi_sram_rd_fifo.sv
// axi_sram_rd_fifo: 2-entry FIFO carrying {rdata, rresp, rlast} between
// the SRAM return path and the R channel.
module axi_sram_rd_fifo
  import axi_sram_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       push_i,
  input  rbeat_t     din_i,
  input  logic       pop_i,
  output rbeat_t     dout_o,
  output logic [1:0] count_o,
  output logic       empty_o
);

  rbeat_t     mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] cnt_q;

  // Storage, pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Overflow is impossible by construction of the issue rule upstream.
  always_ff @(posedge clk) begin
    if (resetn) assert (!(push_i && !pop_i && (cnt_q == 2'd2)));
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/axi_sram_rd_slave.sv
// axi_sram_rd_slave: AXI3 read-channel slave serving FIXED/INCR/WRAP bursts
// from a 1-cycle-latency synchronous SRAM. The returning SRAM word bypasses
// the skid FIFO when it is empty, so beats stream back-to-back with rready=1.
// Optional macro AXI_SRAM_RANGE_CHECK_EN: out-of-range bursts return DECERR.
module axi_sram_rd_slave
  import axi_sram_pkg::*;
#(
  parameter int ID_W    = ID_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SRAM_AW = SRAM_AW_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [ID_W-1:0]    arid,
  input  logic [ADDR_W-1:0]  araddr,
  input  logic [3:0]         arlen,
  input  logic [1:0]         arburst,
  input  logic               arvalid,
  output logic               arready,
  output logic [ID_W-1:0]    rid,
  output logic [DATA_W-1:0]  rdata,
  output logic [1:0]         rresp,
  output logic               rlast,
  output logic               rvalid,
  input  logic               rready,
  output logic               sram_en,
  output logic [SRAM_AW-1:0] sram_addr,
  input  logic [DATA_W-1:0]  sram_rdata
);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    id_q;
  logic [3:0]         len_q;
  burst_e             mode_q, mode_d;
  logic [1:0]         resp_q;
  logic               decerr_q;
  logic [SRAM_AW-1:0] addr_q, addr_nxt, wmask;
  logic [4:0]         issue_cnt_q;
  logic               inflight_q, inflight_last_q;
  logic               rst_done_q;

  logic               ar_hs, pop, issue, range_err;
  logic [2:0]         occ;
  rbeat_t             byp, fifo_dout, head;
  logic [1:0]         fifo_cnt;
  logic               fifo_empty, fifo_push, fifo_pop;
  logic               unused_addr_bits;

`ifdef AXI_SRAM_RANGE_CHECK_EN
  assign range_err        = |araddr[ADDR_W-1:SRAM_AW+2];
  assign unused_addr_bits = ^araddr[1:0];
`else
  // Upper address bits alias onto the SRAM.
  assign range_err        = 1'b0;
  assign unused_addr_bits = ^{araddr[ADDR_W-1:SRAM_AW+2], araddr[1:0]};
`endif

  // FSM next state and AR acceptance; arready stays low until one clean edge out of reset.
  always_comb begin
    state_d = state_q;
    arready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        arready = rst_done_q;
        if (arvalid && rst_done_q) state_d = ST_BURST;
      end
      ST_BURST: begin
        if (rvalid && rready && rlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ar_hs = arvalid && arready;

  // Normalise the burst type: reserved and non-power-of-two WRAP run as INCR.
  always_comb begin
    mode_d = BURST_INCR;
    if (arburst == BURST_FIXED) mode_d = BURST_FIXED;
    else if ((arburst == BURST_WRAP) && wrap_len_ok(arlen)) mode_d = BURST_WRAP;
  end

  // Next word address for the burst in progress.
  always_comb begin
    wmask = {{(SRAM_AW-4){1'b0}}, len_q};
    case (mode_q)
      BURST_FIXED: addr_nxt = addr_q;
      BURST_WRAP:  addr_nxt = (addr_q & ~wmask) | ((addr_q + 1'b1) & wmask);
      default:     addr_nxt = addr_q + 1'b1;
    endcase
  end

  // R head: FIFO entry if any, otherwise the word arriving from the SRAM now.
  always_comb begin
    byp.data = decerr_q ? '0 : sram_rdata;
    byp.resp = resp_q;
    byp.last = inflight_last_q;
    head     = '0;
    if (!fifo_empty)     head = fifo_dout;
    else if (inflight_q) head = byp;
  end

  assign rvalid = !fifo_empty || inflight_q;
  assign rdata  = head.data;
  assign rresp  = head.resp;
  assign rlast  = head.last;
  assign rid    = id_q;
  assign pop    = rvalid && rready;

  // A bypassed beat that is taken this cycle never enters the FIFO.
  assign fifo_push = inflight_q && !(pop && fifo_empty);
  assign fifo_pop  = pop && !fifo_empty;

  // Issue only while the FIFO can absorb everything already requested.
  assign occ       = {1'b0, fifo_cnt} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue     = (state_q == ST_BURST) && (issue_cnt_q <= {1'b0, len_q}) && (occ < 3'd2);
  assign sram_en   = issue && !decerr_q;
  assign sram_addr = addr_q;

  // Burst context, address walk, in-flight tracking and FSM state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q         <= ST_IDLE;
      id_q            <= '0;
      len_q           <= 4'd0;
      mode_q          <= BURST_INCR;
      resp_q          <= RESP_OKAY;
      decerr_q        <= 1'b0;
      addr_q          <= '0;
      issue_cnt_q     <= 5'd0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      rst_done_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      rst_done_q      <= 1'b1;
      inflight_q      <= issue;
      inflight_last_q <= issue && (issue_cnt_q[3:0] == len_q);
      if (ar_hs) begin
        id_q        <= arid;
        len_q       <= arlen;
        mode_q      <= mode_d;
        decerr_q    <= range_err;
        resp_q      <= range_err ? RESP_DECERR :
                       (arburst == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY;
        addr_q      <= araddr[SRAM_AW+1:2];
        issue_cnt_q <= 5'd0;
      end else if (issue) begin
        addr_q      <= addr_nxt;
        issue_cnt_q <= issue_cnt_q + 5'd1;
      end
    end
  end

  axi_sram_rd_fifo u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (fifo_push),
    .din_i   (byp),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_axi_sram_rd_slave.sv
// tb_axi_sram_rd_slave: directed stimulus with a scoreboard of expected R beats.
module tb_axi_sram_rd_slave;

  logic        clk, resetn;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        sram_en;
  logic [13:0] sram_addr;
  logic [31:0] sram_rdata;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [0:16383];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          beats    = 0;

  axi_sram_rd_slave dut (
    .clk(clk), .resetn(resetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .sram_en(sram_en), .sram_addr(sram_addr), .sram_rdata(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (sram_en) sram_rdata <= mem[sram_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push the expected beats, present AR, return one cycle after the handshake edge.
  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [1:0] burst);
    exp_t e;
    int   s, b, nb, n, w;
    logic wrap_ok, rng;
    s  = int'(addr[15:2]);
    nb = int'(len) + 1;
    b  = (s / nb) * nb;
    wrap_ok = (burst == 2'b10) && (len == 1 || len == 3 || len == 7 || len == 15);
    rng = 1'b0;
`ifdef AXI_SRAM_RANGE_CHECK_EN
    rng = (addr[31:16] != 16'd0);
`endif
    for (int i = 0; i < nb; i++) begin
      if (burst == 2'b00) w = s;
      else if (wrap_ok)   w = b + ((s - b + i) % nb);
      else                w = (s + i) % 16384;
      e.data = rng ? 32'd0 : mem[w];
      e.resp = rng ? 2'b11 : (burst == 2'b11) ? 2'b10 : 2'b00;
      e.last = (i == nb - 1);
      e.id   = id;
      sb.push_back(e);
    end
    arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arburst = burst;
    n = 0;
    while (!arready && n < 50) begin step(); n++; end
    chk("ar_accept_timeout", 64'(n < 50), 64'(1));
    step();
    arvalid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((sb.size() != 0 || !arready) && n < 100) begin step(); n++; end
    chk({tag, "_done"}, 64'(n < 100), 64'(1));
  endtask

  // R monitor: scoreboard compare on handshake, hold check while stalled.
  initial begin
    logic        stall;
    logic [31:0] h_data;
    logic [1:0]  h_resp;
    logic        h_last;
    logic [3:0]  h_id;
    exp_t        e;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) stall = 1'b0;
      else begin
        if (stall) begin
          chk("hold_rvalid", 64'(rvalid), 64'(1));
          chk("hold_rdata",  64'(rdata),  64'(h_data));
          chk("hold_rresp",  64'(rresp),  64'(h_resp));
          chk("hold_rlast",  64'(rlast),  64'(h_last));
          chk("hold_rid",    64'(rid),    64'(h_id));
        end
        if (rvalid && rready) begin
          beats++;
          chk("beat_expected", 64'(sb.size() != 0), 64'(1));
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("r_data", 64'(rdata), 64'(e.data));
            chk("r_resp", 64'(rresp), 64'(e.resp));
            chk("r_last", 64'(rlast), 64'(e.last));
            chk("r_id",   64'(rid),   64'(e.id));
          end
        end
        stall  = rvalid && !rready;
        h_data = rdata; h_resp = rresp; h_last = rlast; h_id = rid;
      end
    end
  end

  initial begin
    int          n, b0;
    logic [7:0]  pat;
    for (int i = 0; i < 16384; i++) mem[i] = {i[15:0] ^ 16'h5A5A, ~i[15:0]};
    mem[4] = 32'hDEADBEEF;
    resetn = 1'b0; rready = 1'b1; arvalid = 1'b0;
    arid = 4'd0; araddr = 32'd0; arlen = 4'd0; arburst = 2'b01;
    step(); step(); step();
    chk("rst_arready",   64'(arready),   64'(0));
    chk("rst_rvalid",    64'(rvalid),    64'(0));
    chk("rst_rlast",     64'(rlast),     64'(0));
    chk("rst_sram_en",   64'(sram_en),   64'(0));
    chk("rst_rid",       64'(rid),       64'(0));
    chk("rst_rdata",     64'(rdata),     64'(0));
    chk("rst_rresp",     64'(rresp),     64'(0));
    chk("rst_sram_addr", 64'(sram_addr), 64'(0));
    resetn = 1'b1;
    step();
    chk("post_rst_arready", 64'(arready), 64'(1));

    // Single beat with cycle-exact timing.
    ar_send(4'd3, 32'h10, 4'd0, 2'b01);
    chk("sb_t1_sram_en",   64'(sram_en),   64'(1));
    chk("sb_t1_sram_addr", 64'(sram_addr), 64'(4));
    chk("sb_t1_arready",   64'(arready),   64'(0));
    chk("sb_t1_rvalid",    64'(rvalid),    64'(0));
    step();
    chk("sb_t2_rvalid", 64'(rvalid), 64'(1));
    chk("sb_t2_rdata",  64'(rdata),  64'(32'hDEADBEEF));
    chk("sb_t2_rid",    64'(rid),    64'(3));
    chk("sb_t2_rlast",  64'(rlast),  64'(1));
    chk("sb_t2_rresp",  64'(rresp),  64'(0));
    step();
    chk("sb_t3_arready", 64'(arready), 64'(1));
    chk("sb_t3_rvalid",  64'(rvalid),  64'(0));

    // INCR 4 beats, consecutive timing.
    ar_send(4'd1, 32'h20, 4'd3, 2'b01);
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) begin
        chk("incr_sram_en",   64'(sram_en),   64'(1));
        chk("incr_sram_addr", 64'(sram_addr), 64'(7 + k));
      end
      if (k >= 2) begin
        chk("incr_rvalid", 64'(rvalid), 64'(1));
        chk("incr_rlast",  64'(rlast),  64'(k == 5));
      end
      step();
    end
    chk("incr_arready_after", 64'(arready), 64'(1));
    wait_done("incr");

    ar_send(4'd2, 32'h38, 4'd3, 2'b10);   wait_done("wrap");
    ar_send(4'd4, 32'h40, 4'd2, 2'b00);   wait_done("fixed");
    ar_send(4'd5, 32'h48, 4'd2, 2'b10);   wait_done("wrap_illegal_len");
    ar_send(4'd6, 32'h60, 4'd1, 2'b11);   wait_done("rsvd_slverr");
    ar_send(4'd7, 32'hFFF8, 4'd3, 2'b01); wait_done("incr_rollover");

    // Backpressure, 8 beats.
    b0  = beats;
    pat = 8'b0110_1001;
    ar_send(4'd8, 32'h200, 4'd7, 2'b01);
    n = 0;
    while ((sb.size() != 0 || !arready) && n < 200) begin
      rready = pat[n % 8];
      chk("occupancy_le_2",
          64'((int'(dut.u_fifo.count_o) + int'(dut.inflight_q)) <= 2), 64'(1));
      step();
      n++;
    end
    rready = 1'b1;
    chk("bp_done", 64'(n < 200), 64'(1));
    chk("bp_beat_count", 64'(beats - b0), 64'(8));

`ifdef AXI_SRAM_RANGE_CHECK_EN
    b0 = beats;
    ar_send(4'd9, 32'h0010_0000, 4'd1, 2'b01);
    n = 0;
    while ((sb.size() != 0 || !arready) && n < 50) begin
      chk("decerr_no_sram_en", 64'(sram_en), 64'(0));
      step();
      n++;
    end
    chk("decerr_done", 64'(n < 50), 64'(1));
    chk("decerr_beats", 64'(beats - b0), 64'(2));
`else
    ar_send(4'd9, 32'h0010_0010, 4'd0, 2'b01); wait_done("alias");
`endif

    // Reset during the third beat of an 8-beat burst.
    ar_send(4'd10, 32'h300, 4'd7, 2'b01);
    step(); step(); step();
    resetn = 1'b0;
    step();
    chk("midrst_rvalid",  64'(rvalid),  64'(0));
    chk("midrst_arready", 64'(arready), 64'(0));
    chk("midrst_sram_en", 64'(sram_en), 64'(0));
    sb.delete();
    resetn = 1'b1;
    step();
    chk("midrst_arready_back", 64'(arready), 64'(1));
    ar_send(4'd11, 32'h10, 4'd0, 2'b01); wait_done("post_rst_single");

    step(); step();
    chk("sb_empty_end", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
